// File: rtl/bsr_pkg.sv
// ---------------------------------------------------------------------------
// bsr_pkg
// Shared types and constants for the BSR sparse-matrix front end.
//   walker_state_e : state encoding of the metadata walker FSM
//   BSR_WORD_BYTES : byte stride of one row_ptr / col_idx entry
//   blk_desc_t     : block descriptor {row, col, idx, last}; also consumed by
//                    the PE tile scheduler
//   bsr_word_addr  : base + index * BSR_WORD_BYTES, 32-bit modulo wrap
// ---------------------------------------------------------------------------
package bsr_pkg;

  localparam int BSR_WORD_BYTES = 4;
  localparam int BSR_IDX_W      = 16;
  localparam int BSR_COL_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RP_REQ   = 3'd1,
    ST_RP_WAIT  = 3'd2,
    ST_CI_REQ   = 3'd3,
    ST_CI_WAIT  = 3'd4,
    ST_EMIT     = 3'd5,
    ST_NEXT_ROW = 3'd6,
    ST_FIN      = 3'd7
  } walker_state_e;

  typedef struct packed {
    logic [BSR_IDX_W-1:0] row;
    logic [BSR_COL_W-1:0] col;
    logic [BSR_IDX_W-1:0] idx;
    logic                 last;
  } blk_desc_t;

  // Index is zero-extended by the caller; the product wraps modulo 2^32.
  function automatic logic [31:0] bsr_word_addr(input logic [31:0] base,
                                                input logic [31:0] index);
    return base + (index * 32'(BSR_WORD_BYTES));
  endfunction

endpackage

// File: rtl/bsr_meta_walker.sv
// ---------------------------------------------------------------------------
// bsr_meta_walker
// Walks the row_ptr / col_idx arrays of a BSR matrix through a single-
// outstanding metadata read port and emits one descriptor per nonzero block.
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   start                    : one-cycle pulse, begins a walk (ignored if busy)
//   num_block_rows           : block-row count, sampled on start
//   row_ptr_base/col_idx_base: byte bases of the arrays, sampled on start
//   req_valid/req_addr/req_ready     : metadata read request
//   meta_valid/meta_rdata/meta_ready : metadata read response
//   blk_valid/blk_row/blk_col/blk_idx/blk_last/blk_ready : descriptor out
//   busy, done, err          : walk in progress, end pulse, sticky bad-ptr flag
//   dbg_state                : current FSM state for observation
//
// Handshakes: every channel transfers on a cycle where valid & ready are both
// high at the rising clock edge. Once valid is raised it stays high with its
// payload (req_addr, blk_*) unchanged until that transfer happens.
// ---------------------------------------------------------------------------
module bsr_meta_walker
  import bsr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 16,
  parameter int COL_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IDX_W-1:0]      num_block_rows,
  input  logic [31:0]           row_ptr_base,
  input  logic [31:0]           col_idx_base,
  output logic                  req_valid,
  output logic [31:0]           req_addr,
  input  logic                  req_ready,
  input  logic                  meta_valid,
  input  logic [DATA_WIDTH-1:0] meta_rdata,
  output logic                  meta_ready,
  output logic                  blk_valid,
  output logic [IDX_W-1:0]      blk_row,
  output logic [COL_W-1:0]      blk_col,
  output logic [IDX_W-1:0]      blk_idx,
  output logic                  blk_last,
  input  logic                  blk_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output walker_state_e         dbg_state
);

  walker_state_e    state_q, state_d;
  logic [IDX_W-1:0] nrows_q, nrows_d;
  logic [31:0]      rp_base_q, rp_base_d;
  logic [31:0]      ci_base_q, ci_base_d;
  logic [IDX_W-1:0] r_q, r_d;
  logic [IDX_W-1:0] ptr_idx_q, ptr_idx_d;
  logic [IDX_W-1:0] cur_start_q, cur_start_d;
  logic [IDX_W-1:0] cur_end_q, cur_end_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [IDX_W-1:0] blk_row_q, blk_row_d;
  logic [COL_W-1:0] blk_col_q, blk_col_d;
  logic [IDX_W-1:0] blk_idx_q, blk_idx_d;
  logic             blk_last_q, blk_last_d;
  logic             err_q, err_d;

  // row_ptr values are counted in IDX_W bits; upper word bits are dropped.
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] k_inc;
  logic [IDX_W-1:0] r_inc;
  logic             unused_rdata;

  assign rd_idx       = meta_rdata[IDX_W-1:0];
  assign k_inc        = k_q + IDX_W'(1);
  assign r_inc        = r_q + IDX_W'(1);
  assign unused_rdata = ^meta_rdata;

  always_comb begin
    state_d     = state_q;
    nrows_d     = nrows_q;
    rp_base_d   = rp_base_q;
    ci_base_d   = ci_base_q;
    r_d         = r_q;
    ptr_idx_d   = ptr_idx_q;
    cur_start_d = cur_start_q;
    cur_end_d   = cur_end_q;
    k_d         = k_q;
    blk_row_d   = blk_row_q;
    blk_col_d   = blk_col_q;
    blk_idx_d   = blk_idx_q;
    blk_last_d  = blk_last_q;
    err_d       = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          nrows_d   = num_block_rows;
          rp_base_d = row_ptr_base;
          ci_base_d = col_idx_base;
          err_d     = 1'b0;
          r_d       = '0;
          ptr_idx_d = '0;
          k_d       = '0;
          state_d   = (num_block_rows == '0) ? ST_FIN : ST_RP_REQ;
        end
      end
      ST_RP_REQ: begin
        if (req_ready) state_d = ST_RP_WAIT;
      end
      ST_RP_WAIT: begin
        if (meta_valid) begin
          if (ptr_idx_q == '0) begin
            // Only the very first row needs its start pointer fetched; later
            // rows inherit the previous row's end pointer.
            cur_start_d = rd_idx;
            ptr_idx_d   = IDX_W'(1);
            state_d     = ST_RP_REQ;
          end else begin
            cur_end_d = rd_idx;
            k_d       = cur_start_q;
            if (rd_idx < cur_start_q) err_d = 1'b1;
            // A decreasing pointer pair is handled as an empty row.
            state_d = (rd_idx <= cur_start_q) ? ST_NEXT_ROW : ST_CI_REQ;
          end
        end
      end
      ST_CI_REQ: begin
        if (req_ready) state_d = ST_CI_WAIT;
      end
      ST_CI_WAIT: begin
        if (meta_valid) begin
          blk_row_d  = r_q;
          blk_col_d  = meta_rdata[COL_W-1:0];
          blk_idx_d  = k_q;
          blk_last_d = (k_inc == cur_end_q);
          state_d    = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (blk_ready) begin
          k_d     = k_inc;
          state_d = (k_inc < cur_end_q) ? ST_CI_REQ : ST_NEXT_ROW;
        end
      end
      ST_NEXT_ROW: begin
        cur_start_d = cur_end_q;
        r_d         = r_inc;
        ptr_idx_d   = ptr_idx_q + IDX_W'(1);
        state_d     = (r_inc == nrows_q) ? ST_FIN : ST_RP_REQ;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      nrows_q     <= '0;
      rp_base_q   <= '0;
      ci_base_q   <= '0;
      r_q         <= '0;
      ptr_idx_q   <= '0;
      cur_start_q <= '0;
      cur_end_q   <= '0;
      k_q         <= '0;
      blk_row_q   <= '0;
      blk_col_q   <= '0;
      blk_idx_q   <= '0;
      blk_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      nrows_q     <= nrows_d;
      rp_base_q   <= rp_base_d;
      ci_base_q   <= ci_base_d;
      r_q         <= r_d;
      ptr_idx_q   <= ptr_idx_d;
      cur_start_q <= cur_start_d;
      cur_end_q   <= cur_end_d;
      k_q         <= k_d;
      blk_row_q   <= blk_row_d;
      blk_col_q   <= blk_col_d;
      blk_idx_q   <= blk_idx_d;
      blk_last_q  <= blk_last_d;
      err_q       <= err_d;
    end
  end

  // Address depends only on registered state, so it cannot move while a
  // request is waiting for req_ready.
  always_comb begin
    req_addr = '0;
    if (state_q == ST_RP_REQ) req_addr = bsr_word_addr(rp_base_q, 32'(ptr_idx_q));
    else if (state_q == ST_CI_REQ) req_addr = bsr_word_addr(ci_base_q, 32'(k_q));
  end

  assign req_valid  = (state_q == ST_RP_REQ) || (state_q == ST_CI_REQ);
  assign meta_ready = (state_q == ST_RP_WAIT) || (state_q == ST_CI_WAIT);
  assign blk_valid  = (state_q == ST_EMIT);
  assign blk_row    = blk_row_q;
  assign blk_col    = blk_col_q;
  assign blk_idx    = blk_idx_q;
  assign blk_last   = blk_last_q;
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done       = (state_q == ST_FIN);
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule
